fifo_word_packer: RTL and testbench

Downstream consumer of the synchronous byte FIFO: pops DATA_WIDTH-bit entries through the FIFO read port (r_en / data_out / empty) and packs PACK consecutive entries into one wide word on a valid/ready output. A flush request emits a partial word with a lane-keep mask. The output typically feeds a bus-width converter or sink monitor in the layered bench.

---
 rtl/fifo_word_packer.sv | 133 +++++++++++++
 tb/tb_fifo_word_packer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops DATA_WIDTH-bit entries from a synchronous FIFO read port
// and packs PACK of them into one wide word on a valid/ready output. A flush
// request emits a partially filled word with a lane-keep mask.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   fifo_empty   FIFO empty flag
//   fifo_rd_en   FIFO read enable (combinational, drives FIFO r_en)
//   fifo_data    FIFO data_out, valid the cycle after an accepted read
//   flush        single-cycle request to emit any partial word
//   out_valid    output word valid
//   out_ready    downstream accept
//   out_data     packed word, lane 0 is the oldest entry
//   out_keep     per-lane valid mask
//   out_last     word was terminated by a flush
module fifo_word_packer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PACK       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]        fifo_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH*PACK-1:0]   out_data,
    output logic [PACK-1:0]              out_keep,
    output logic                         out_last
);

    localparam int unsigned CW = $clog2(PACK + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   lane_cnt;
    logic            inflight;
    logic            flush_pend;

    logic [CW:0]     occupancy;
    logic [CW-1:0]   cnt_cap;
    logic            flush_eff;
    logic [PACK-1:0] part_keep;

    // Lanes already captured plus the one still travelling out of the FIFO.
    assign occupancy = {1'b0, lane_cnt} + (CW+1)'(inflight);
    assign cnt_cap   = lane_cnt + CW'(inflight);
    assign flush_eff = flush_pend | flush;

    // Read only while there is room for the returning entry.
    assign fifo_rd_en = (state == FILL) && !fifo_empty && !flush_pend && !rst &&
                        (occupancy < (CW+1)'(PACK));

    // Keep mask for a partial word: one bit per captured lane.
    always_comb begin
        part_keep = '0;
        for (int i = 0; i < int'(PACK); i++) begin
            part_keep[i] = (CW'(i) < lane_cnt);
        end
    end

    // Packer state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            lane_cnt   <= '0;
            inflight   <= 1'b0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (flush) begin
                flush_pend <= 1'b1;
            end
            case (state)
                FILL: begin
                    if (inflight) begin
                        for (int i = 0; i < int'(PACK); i++) begin
                            if (lane_cnt == CW'(i)) begin
                                out_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
                            end
                        end
                        lane_cnt <= cnt_cap;
                    end
                    // A completing capture wins; a flush is looked at only once
                    // nothing is left in flight.
                    if (inflight && (cnt_cap == CW'(PACK))) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_keep  <= '1;
                        out_last  <= 1'b0;
                    end else if (!inflight && flush_eff) begin
                        if (lane_cnt != '0) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_keep  <= part_keep;
                            out_last  <= 1'b1;
                        end else begin
                            flush_pend <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= FILL;
                        out_valid <= 1'b0;
                        lane_cnt  <= '0;
                        out_data  <= '0;
                        out_keep  <= '0;
                        out_last  <= 1'b0;
                        // The flush that produced this word is done; a fresh
                        // pulse in the same cycle stays pending.
                        if (out_last && !flush) begin
                            flush_pend <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
module tb_fifo_word_packer;

    localparam int unsigned DW = 8;
    localparam int unsigned PK = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [DW-1:0]    fifo_data = '0;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [DW*PK-1:0] out_data;
    logic [PK-1:0]    out_keep;
    logic             out_last;

    fifo_word_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    // FIFO model: storage written by the stimulus, read pointer owned by the pop logic.
    logic [DW-1:0] mem [256];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          gap = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr) || gap;

    int rd_count = 0;
    int underflow = 0;
    int drop_cnt = 0;
    logic             hold_q = 1'b0;
    logic [DW*PK-1:0] held_q = '0;

    logic [DW*PK-1:0] got_data [$];
    logic [PK-1:0]    got_keep [$];
    logic             got_last [$];

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_count <= rd_count + 1;
            if (fifo_empty) begin
                underflow <= underflow + 1;
            end else begin
                fifo_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
        if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_keep.push_back(out_keep);
            got_last.push_back(out_last);
        end
        if (!rst && hold_q && (!out_valid || out_data != held_q)) begin
            drop_cnt <= drop_cnt + 1;
        end
        hold_q <= out_valid && !out_ready && !rst;
        held_q <= out_data;
    end

    int pass_cnt = 0;
    int fail_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (got_data.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(got_data.size()), 64'(n));
    endtask

    int base_w;
    int base_rd;
    logic [DW-1:0]    pb;
    logic [DW*PK-1:0] exp_w;

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data",  64'(out_data),  64'd0);
        check("rst_keep",  64'(out_keep),  64'd0);
        check("rst_last",  64'(out_last),  64'd0);
        check("rst_rden",  64'(fifo_rd_en), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full word and first-read-to-valid latency.
        out_ready = 1'b1;
        base_w = got_data.size(); base_rd = rd_count;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("lat_not_yet", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_valid", 64'(out_valid), 64'd1);
        wait_words(base_w + 1, 20, "w1_count");
        check("w1_data", 64'(got_data[base_w]), 64'h44332211);
        check("w1_keep", 64'(got_keep[base_w]), 64'hf);
        check("w1_last", 64'(got_last[base_w]), 64'd0);
        repeat (3) @(negedge clk);
        check("w1_reads", 64'(rd_count - base_rd), 64'd4);

        // Partial word via flush.
        base_w = got_data.size(); base_rd = rd_count;
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_words(base_w + 1, 20, "fl_count");
        check("fl_data", 64'(got_data[base_w]), 64'h00A3A2A1);
        check("fl_keep", 64'(got_keep[base_w]), 64'h7);
        check("fl_last", 64'(got_last[base_w]), 64'd1);
        repeat (6) @(negedge clk);
        check("fl_reads", 64'(rd_count - base_rd), 64'd3);
        check("fl_idle",  64'(out_valid), 64'd0);

        // Backpressure holds the word and stops reads.
        out_ready = 1'b0;
        base_w = got_data.size(); base_rd = rd_count;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (15) @(negedge clk);
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_data",  64'(out_data),  64'h04030201);
        check("bp_reads", 64'(rd_count - base_rd), 64'd4);
        repeat (10) @(negedge clk);
        check("bp_valid2", 64'(out_valid), 64'd1);
        check("bp_data2",  64'(out_data),  64'h04030201);
        check("bp_reads2", 64'(rd_count - base_rd), 64'd4);
        out_ready = 1'b1;
        wait_words(base_w + 2, 30, "bp_count");
        check("bp_w1", 64'(got_data[base_w]),     64'h04030201);
        check("bp_w2", 64'(got_data[base_w + 1]), 64'h08070605);
        check("bp_k2", 64'(got_keep[base_w + 1]), 64'hf);
        check("bp_l2", 64'(got_last[base_w + 1]), 64'd0);

        // Flush with nothing captured: no word, pending flag gone.
        repeat (3) @(negedge clk);
        base_w = got_data.size();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fe_pend", 64'(dut.flush_pend), 64'd0);
        repeat (6) @(negedge clk);
        check("fe_words", 64'(got_data.size()), 64'(base_w));
        check("fe_valid", 64'(out_valid), 64'd0);

        // Reset with two lanes captured and one read in flight.
        base_w = got_data.size();
        push(8'hD1); push(8'hD2); push(8'hD3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mr_lanes",    64'(dut.lane_cnt), 64'd2);
        check("mr_inflight", 64'(dut.inflight), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_data",  64'(out_data),  64'd0);
        check("mr_keep",  64'(out_keep),  64'd0);
        check("mr_last",  64'(out_last),  64'd0);
        check("mr_rden",  64'(fifo_rd_en), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        wait_words(base_w + 1, 20, "mr_count");
        check("mr_word", 64'(got_data[base_w]), 64'hC4C3C2C1);
        check("mr_wkeep", 64'(got_keep[base_w]), 64'hf);

        // Random empty gaps and backpressure over 64 bytes.
        base_w = got_data.size();
        for (int i = 0; i < 64; i++) push(8'(i * 7 + 3));
        for (int c = 0; c < 3000 && got_data.size() < base_w + 16; c++) begin
            out_ready = ($urandom_range(0, 1) == 1);
            gap = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        gap = 1'b0;
        out_ready = 1'b1;
        wait_words(base_w + 16, 50, "rnd_count");
        for (int w = 0; w < 16; w++) begin
            exp_w = '0;
            for (int l = 0; l < 4; l++) begin
                pb = 8'((4 * w + l) * 7 + 3);
                exp_w[l*8 +: 8] = pb;
            end
            if (base_w + w < got_data.size()) begin
                check($sformatf("rnd_w%0d", w), 64'(got_data[base_w + w]), 64'(exp_w));
            end
        end
        check("underflow", 64'(underflow), 64'd0);
        check("valid_drop", 64'(drop_cnt), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule
